// File: rtl/mips_pkg.sv
//==============================================================================
// Package : mips_pkg -- shared widths and instruction encodings for the IF stage
// Rev     : 1.0
//==============================================================================
`default_nettype none

package mips_pkg;

  localparam int NB_DATA    = 32;
  localparam int NB_ADDR    = 32;
  localparam int IMEM_DEPTH = 256;
  localparam int IMEM_WADDR = $clog2(IMEM_DEPTH);

  localparam logic [NB_DATA-1:0] INSTR_NOP  = 32'h0000_0000;
  localparam logic [NB_DATA-1:0] INSTR_HALT = 32'hFFFF_FFFF;

endpackage

`default_nettype wire

// File: rtl/instr_fetch_stage_if.sv
//==============================================================================
// Interface : instr_fetch_stage_if -- PC/loader inputs and IF/ID outputs
// Rev       : 1.0
//==============================================================================
`default_nettype none

interface instr_fetch_stage_if
  import mips_pkg::*;
#(
  parameter int MEM_DEPTH = IMEM_DEPTH,
  parameter int NB_WADDR  = $clog2(MEM_DEPTH)
);

  logic [NB_ADDR-1:0]  i_pc;
  logic [NB_ADDR-1:0]  i_pc4;
  logic                i_stall;
  logic                i_flush;
  logic                i_load_mode;
  logic                i_we;
  logic [NB_WADDR-1:0] i_wr_addr;
  logic [NB_DATA-1:0]  i_wr_data;
  logic [NB_DATA-1:0]  o_instr;
  logic [NB_ADDR-1:0]  o_pc4;
  logic                o_valid;
  logic                o_halt;
  logic [31:0]         o_fetch_cnt;

  modport master (
    output i_pc, i_pc4, i_stall, i_flush, i_load_mode, i_we, i_wr_addr, i_wr_data,
    input  o_instr, o_pc4, o_valid, o_halt, o_fetch_cnt
  );

  modport slave (
    input  i_pc, i_pc4, i_stall, i_flush, i_load_mode, i_we, i_wr_addr, i_wr_data,
    output o_instr, o_pc4, o_valid, o_halt, o_fetch_cnt
  );

endinterface

`default_nettype wire

// File: rtl/instr_fetch_stage_mem.sv
//==============================================================================
// Module : instr_mem -- word-wide instruction memory, sync write / async read
// Rev    : 1.0
//==============================================================================
`default_nettype none

module instr_mem
  import mips_pkg::*;
#(
  parameter int MEM_DEPTH = IMEM_DEPTH,
  parameter int NB_WADDR  = $clog2(MEM_DEPTH)
) (
  input  wire logic                clk,
  input  wire logic                i_we,
  input  wire logic [NB_WADDR-1:0] i_waddr,
  input  wire logic [NB_DATA-1:0]  i_wdata,
  input  wire logic [NB_WADDR-1:0] i_raddr,
  output      logic [NB_DATA-1:0]  o_rdata
);

  logic [NB_DATA-1:0] r_mem [MEM_DEPTH];

  // No reset: program contents survive a core reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/instr_fetch_stage.sv
//==============================================================================
// Module : instr_fetch_stage -- imem read, IF/ID latch, sticky HALT, fetch count
// Rev    : 1.0
//==============================================================================
`default_nettype none

module instr_fetch_stage
  import mips_pkg::*;
#(
  parameter int MEM_DEPTH = IMEM_DEPTH,
  parameter int NB_WADDR  = $clog2(MEM_DEPTH)
) (
  input  wire logic         clk,
  input  wire logic         i_rst,
  instr_fetch_stage_if.slave bus
);

  logic [NB_DATA-1:0] w_mem_rdata;
  logic               w_misalign;
  logic               w_out_of_range;
  logic [NB_DATA-1:0] w_fetch_word;

  logic [NB_DATA-1:0] r_instr;
  logic [NB_ADDR-1:0] r_pc4;
  logic               r_valid;
  logic               r_halt;
  logic [31:0]        r_fetch_cnt;

  instr_mem #(
    .MEM_DEPTH (MEM_DEPTH),
    .NB_WADDR  (NB_WADDR)
  ) u_instr_mem (
    .clk     (clk),
    .i_we    (bus.i_load_mode & bus.i_we),
    .i_waddr (bus.i_wr_addr),
    .i_wdata (bus.i_wr_data),
    .i_raddr (bus.i_pc[2 +: NB_WADDR]),
    .o_rdata (w_mem_rdata)
  );

  // Index bits alone would alias high PCs onto low words, so range-check the full PC.
  assign w_misalign     = |bus.i_pc[1:0];
  assign w_out_of_range = (bus.i_pc >> 2) >= NB_ADDR'(MEM_DEPTH);
  assign w_fetch_word   = (w_misalign || w_out_of_range) ? INSTR_NOP : w_mem_rdata;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_instr     <= INSTR_NOP;
      r_pc4       <= '0;
      r_valid     <= 1'b0;
      r_halt      <= 1'b0;
      r_fetch_cnt <= '0;
    end else if (bus.i_load_mode) begin
      r_instr     <= INSTR_NOP;
      r_pc4       <= '0;
      r_valid     <= 1'b0;
      r_halt      <= 1'b0;
      r_fetch_cnt <= '0;
    end else if (r_halt || bus.i_flush) begin
      r_instr <= INSTR_NOP;
      r_pc4   <= '0;
      r_valid <= 1'b0;
    end else if (!bus.i_stall) begin
      r_instr     <= w_fetch_word;
      r_pc4       <= bus.i_pc4;
      r_valid     <= 1'b1;
      r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (w_fetch_word == INSTR_HALT) begin
        r_halt <= 1'b1;
      end
    end
  end

  assign bus.o_instr     = r_instr;
  assign bus.o_pc4       = r_pc4;
  assign bus.o_valid     = r_valid;
  assign bus.o_halt      = r_halt;
  assign bus.o_fetch_cnt = r_fetch_cnt;

endmodule

`default_nettype wire
